// File: rtl/display_pkg.sv
// display_pkg: glyph codes, mode encodings, composer states and word composition
package display_pkg;
  localparam logic [3:0] GLYPH_N   = 4'hA;
  localparam logic [3:0] GLYPH_D   = 4'hB;
  localparam logic [3:0] GLYPH_R   = 4'hC;
  localparam logic [3:0] GLYPH_A   = 4'hD;
  localparam logic [3:0] GLYPH_W   = 4'hE;
  localparam logic [3:0] GLYPH_OFF = 4'hF;
  typedef enum logic [2:0] {
    MODE_BLANK, MODE_NUM, MODE_ROUND, MODE_PLAYER, MODE_WIN, MODE_DRAW
  } mode_e;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;
  function automatic logic [15:0] compose(input logic [2:0] mode, input logic [3:0] player,
                                          input logic [15:0] bcd);
    logic [3:0] d3, d2, d1, p;
    d3 = bcd[15:12] == 4'd0 ? GLYPH_OFF : bcd[15:12];
    d2 = bcd[15:8] == 8'd0 ? GLYPH_OFF : bcd[11:8];
    d1 = bcd[15:4] == 12'd0 ? GLYPH_OFF : bcd[7:4];
    p  = player > 4'd9 ? GLYPH_OFF : player;
    return mode == MODE_NUM    ? {d3, d2, d1, bcd[3:0]} :
           mode == MODE_ROUND  ? {GLYPH_R, GLYPH_D, bcd[7:0]} :
           mode == MODE_PLAYER ? {p, GLYPH_OFF, bcd[7:0]} :
           mode == MODE_WIN    ? {GLYPH_W, 4'h1, GLYPH_N, GLYPH_OFF} :
           mode == MODE_DRAW   ? {GLYPH_D, GLYPH_R, GLYPH_A, GLYPH_W} : 16'hFFFF;
  endfunction
endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 binary to 4-digit BCD, one bit per cycle
module bin_to_bcd_seq #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [15:0]  bcd
);
  localparam int CW = $clog2(W);
  logic [W+15:0] sh, adj;
  logic [CW-1:0] cnt;
  assign adj[W-1:0] = sh[W-1:0];
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[W+4*i +: 4] = sh[W+4*i +: 4] >= 4'd5 ? sh[W+4*i +: 4] + 4'd3 : sh[W+4*i +: 4];
  end
  // done flags the final iteration so the caller can step in lock-step
  assign done = busy && cnt == CW'(W-1);
  assign bcd  = sh[W+15:W];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      sh   <= {16'd0, bin};
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      sh   <= {adj[W+14:0], 1'b0};
      cnt  <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/display_composer.sv
// display_composer: builds the 16-bit glyph word from a display request, with optional blink
module display_composer
  import display_pkg::*;
#(
  parameter int VALUE_W    = 14,
  parameter int BLINK_HALF = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [2:0]         mode,
  input  logic [VALUE_W-1:0] value,
  input  logic [3:0]         player,
  input  logic               blink,
  output logic               ready,
  output logic               done,
  output logic [15:0]        graphics
);
  localparam int CW = $clog2(BLINK_HALF);
  state_e state, next;
  logic [2:0] mode_q;
  logic [3:0] player_q;
  logic blink_q, hidden, hidden_n, wrap, start, busy, conv_done;
  logic [CW-1:0] bcnt, bcnt_n;
  logic [VALUE_W-1:0] lim, clamped;
  logic [15:0] bcd, stored, word;
  assign lim     = mode == MODE_NUM ? VALUE_W'(9999) : VALUE_W'(99);
  assign clamped = value > lim ? lim : value;
  assign ready   = state == IDLE && !busy;
  assign start   = load && ready;
  assign word    = compose(mode_q, player_q, bcd);
  bin_to_bcd_seq #(.W(VALUE_W)) u_bcd (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(clamped),
    .busy(busy), .done(conv_done), .bcd(bcd)
  );
  always_comb begin
    next     = state == IDLE ? (start ? CONV : IDLE) :
               state == CONV ? (conv_done ? COMMIT : CONV) : IDLE;
    wrap     = blink_q && bcnt == CW'(BLINK_HALF - 1);
    bcnt_n   = (!blink_q || wrap) ? '0 : bcnt + 1'b1;
    hidden_n = hidden ^ wrap;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= '0;
      player_q <= '0;
      blink_q  <= 1'b0;
      stored   <= 16'hFFFF;
      graphics <= 16'hFFFF;
      done     <= 1'b0;
      hidden   <= 1'b0;
      bcnt     <= '0;
    end else begin
      state <= next;
      done  <= state == COMMIT;
      if (start) begin
        mode_q   <= mode;
        player_q <= player;
        blink_q  <= blink;
      end
      // blink only advances while idle; conversion freezes the visible phase
      if (state == COMMIT) begin
        stored   <= word;
        graphics <= word;
        bcnt     <= '0;
        hidden   <= 1'b0;
      end else if (state == IDLE) begin
        bcnt     <= bcnt_n;
        hidden   <= hidden_n;
        graphics <= hidden_n ? 16'hFFFF : stored;
      end
    end
  end
endmodule

// File: doc/display_composer.md
Name: display_composer

Overview:
Upstream feeder for the 4-digit seven-segment renderer. Takes a display request from the game FSM (message mode, number, player id, blink flag) and builds the 16-bit glyph word `graphics` the renderer consumes. Digit 3 is `graphics[15:12]` (leftmost) and digit 0 is `graphics[3:0]` (rightmost). Binary-to-BCD conversion is sequential (shift-add-3), and the composed word is committed atomically, so the renderer never sees a partial word. An optional blink gate alternates the committed message with blank.

Parameters:
- VALUE_W, 14, width of binary `value` input (0..16383).
- BLINK_HALF, 50000000, clock cycles per blink half-period (0.5 s at 100 MHz); must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- load  input  1  request strobe; accepted only when ready=1.
- mode  input  3  message select, sampled on accepted load.
- value  input  VALUE_W  binary number, sampled on accepted load.
- player  input  4  player digit 0..9, sampled on accepted load.
- blink  input  1  blink enable, sampled on accepted load.
- ready  output  1  composer idle, can accept load.
- done  output  1  one-cycle pulse when a new message is committed.
- graphics  output  16  glyph word to the renderer (registered).

Behaviour:
- Glyph codes: 0-9 digits, A=N, B=D, C=R, D=A, E=W, F=blank.
- Reset (async, rst_n=0):
  - graphics=16'hFFFF, ready=1, done=0.
  - State IDLE, blink phase visible, blink counter 0, stored message 16'hFFFF.
- States:
  - IDLE: ready=1. On load=1 at edge N: capture inputs. Clamp value to the mode maximum (NUM: 9999, ROUND/PLAYER: 99). Go to CONV with iteration count 0. ready drops after edge N.
  - CONV: 14 iterations at edges N+1..N+14. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts left one bit. The last iteration moves to COMMIT.
  - COMMIT: at edge N+15, the stored message and graphics take the composed word, done=1 for one cycle, ready=1, state goes to IDLE, blink counter resets to 0 and phase to visible.
- Latency: fixed 15 cycles from the accepted load edge to the graphics update, for every mode including non-numeric ones.
- Composition by mode:
  - 0 BLANK: FFFF.
  - 1 NUM: 4 BCD digits with leading zeros blanked; value 0 shows FFF0.
  - 2 ROUND: {C, B, tens, ones}, shown as "Rd07". Leading zero kept.
  - 3 PLAYER: {player, F, tens, ones}. A player value > 9 is forced to F.
  - 4 WIN: {E, 1, A, F}, shown as "W1N ".
  - 5 DRAW: {B, C, D, E}, shown as "dRAW".
  - 6, 7 reserved: FFFF.
- load while ready=0 is ignored entirely; no queuing.
- Blink (while the captured blink=1 and the state is IDLE):
  - The counter runs 0..BLINK_HALF-1. On wrap, phase toggles.
  - graphics = phase hidden ? FFFF : stored message.
  - With blink=0, graphics holds the stored message and the counter stays at 0.
- During CONV/COMMIT, graphics keeps its previous value, including its current blink phase frozen.
- Reset asserted mid-conversion aborts the conversion: reset values apply immediately, and no done pulse is issued.

Decomposition:
- Package `display_pkg`:
  - Glyph constants GLYPH_N=4'hA, GLYPH_D=4'hB, GLYPH_R=4'hC, GLYPH_A=4'hD, GLYPH_W=4'hE, GLYPH_OFF=4'hF.
  - Mode encodings MODE_BLANK..MODE_DRAW.
  - Composer state enum.
- Sub-module `bin_to_bcd_seq` (start/busy/done, 14-bit in, 16-bit BCD out, 14 iterations). It is instantiated once; the composer FSM sequences it and owns clamping, composition and blink.

Test Plan:
- Reset, then load mode=1 value=42 blink=0 → ready low for 15 cycles, graphics=16'hFF42 at N+15, done high exactly 1 cycle.
- mode=1 value=12345 → clamps to 9999; graphics=16'h9999. Separately, value=0 → 16'hFFF0.
- mode=2 value=7 → 16'hCB07. Then mode=3 player=2 value=13 → 16'h2F13. Then player=11 → 16'hFF13.
- mode=5 blink=1, BLINK_HALF=4 → graphics cycles BCDE ×4 cycles, FFFF ×4, BCDE ×4. A new load mid-hidden-phase holds FFFF until commit, then shows visible first.
- load pulsed again at N+5 during conversion → ignored; a single done pulse at N+15 with the first request's word.
- rst_n dropped at N+8 mid-conversion → graphics=FFFF, ready=1 asynchronously; no done pulse after release.
